// File: rtl/data_ram_ws.sv
// Word-organised data memory with byte/halfword/word access, sign/zero extension
// and a fixed number of wait states per access behind a req/ready handshake.
module data_ram_ws #(
  parameter int ADDR_WIDTH  = 5,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH+1:0] addr,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  ready,
  output logic                  err,
  output logic                  busy
);

  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic                    we_p0;
  logic                    sext_p0;
  logic [ADDR_WIDTH+1:0]   addr_p0;
  logic [1:0]              size_p0;
  logic [DATA_W-1:0]       wdata_p0;
  logic [DATA_W-1:0]       mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   word_idx;
  logic                    access;

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lo);
    return (sz == 2'b11) || (sz == 2'b01 && lo[0]) || (sz == 2'b10 && lo != 2'b00);
  endfunction

  // Only the addressed lanes take the low bits of the store data.
  function automatic logic [DATA_W-1:0] merge_store(input logic [DATA_W-1:0] old,
                                                    input logic [DATA_W-1:0] wd,
                                                    input logic [1:0]        sz,
                                                    input logic [1:0]        lo);
    logic [DATA_W-1:0] r;
    r = old;
    case (sz)
      2'b00:   r[{lo, 3'b000} +: 8]     = wd[7:0];
      2'b01:   r[{lo[1], 4'b0000} +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] load_extract(input logic [DATA_W-1:0] word,
                                                     input logic [1:0]        sz,
                                                     input logic [1:0]        lo,
                                                     input logic              sx);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = word[{lo, 3'b000} +: 8];
    h = word[{lo[1], 4'b0000} +: 16];
    case (sz)
      2'b00:   return sx ? DATA_W'(b) : {24'h0, b};
      2'b01:   return sx ? DATA_W'(h) : {16'h0, h};
      default: return word;
    endcase
  endfunction

  assign word_idx = addr_p0[ADDR_WIDTH+1:2];
  assign access   = (state == WAIT) && (cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      ready <= 1'b0;
      err   <= 1'b0;
      busy  <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            busy <= 1'b1;
            if (misaligned(size, addr[1:0])) begin
              state <= DONE;
              ready <= 1'b1;
              err   <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= 4'(WAIT_CYCLES);
            end
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= DONE;
            ready <= 1'b1;
            if (!we_p0) rdata <= load_extract(mem[word_idx], size_p0, addr_p0[1:0], sext_p0);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Request capture; later input changes are invisible to the access in flight.
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      we_p0    <= we;
      addr_p0  <= addr;
      size_p0  <= size;
      sext_p0  <= sign_ext;
      wdata_p0 <= wdata;
    end
  end

  // A reset edge suppresses any pending write.
  always_ff @(posedge clk) begin
    if (!rst && access && we_p0)
      mem[word_idx] <= merge_store(mem[word_idx], wdata_p0, size_p0, addr_p0[1:0]);
  end

endmodule

// File: tb/tb_data_ram_ws.sv
// Directed bench for data_ram_ws: latency, sub-word stores/loads, extension,
// error completions, back-to-back requests and reset mid-access.
module tb_data_ram_ws;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [AW+1:0] addr = '0;
  logic [1:0]    size = 2'b10;
  logic          sign_ext = 1'b0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata;
  logic          ready;
  logic          err;
  logic          busy;

  int vectors = 0;
  int miscompares = 0;

  data_ram_ws #(.ADDR_WIDTH(AW), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .size(size),
    .sign_ext(sign_ext), .wdata(wdata), .rdata(rdata), .ready(ready),
    .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request: checks ready latency, err, busy duration and one-cycle ready pulse.
  task automatic access(input string tag, input logic w, input logic [AW+1:0] a,
                        input logic [1:0] s, input logic sx, input logic [31:0] wd,
                        input int exp_lat, input logic exp_err, output logic [31:0] rd);
    int   lat;
    int   bcnt;
    logic e;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; size = s; sign_ext = sx; wdata = wd;
    @(posedge clk);
    #1;
    req = 1'b0; we = ~w; addr = ~a; size = 2'b11; sign_ext = ~sx; wdata = ~wd;
    lat = 0; bcnt = 0; e = 1'b0; rd = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (ready) begin
        lat = k; e = err; rd = rdata;
        break;
      end
    end
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check({tag, ".err"}, {31'h0, e}, {31'h0, exp_err});
    check({tag, ".busy_cycles"}, 32'(bcnt), 32'(exp_lat));
    @(negedge clk);
    check({tag, ".ready_after"}, {31'h0, ready}, 32'h0);
    check({tag, ".busy_after"}, {31'h0, busy}, 32'h0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [10:0] rv;
    logic [10:0] bv;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.ready", {31'h0, ready}, 32'h0);
    check("reset.err",   {31'h0, err},   32'h0);
    check("reset.busy",  {31'h0, busy},  32'h0);
    check("reset.rdata", rdata, 32'h0);
    rst = 1'b0;

    access("sw04", 1'b1, 7'h04, 2'b10, 1'b0, 32'hDEADBEEF, 4, 1'b0, rd);
    check("sw04.rdata_held", rd, 32'h0);
    access("lw04", 1'b0, 7'h04, 2'b10, 1'b1, 32'h0, 4, 1'b0, rd);
    check("lw04.rdata", rd, 32'hDEADBEEF);

    access("sb05", 1'b1, 7'h05, 2'b00, 1'b0, 32'hFFFFFFAA, 4, 1'b0, rd);
    check("sb05.rdata_held", rd, 32'hDEADBEEF);
    access("lw04b", 1'b0, 7'h04, 2'b10, 1'b0, 32'h0, 4, 1'b0, rd);
    check("lw04b.rdata", rd, 32'hDEADAAEF);
    access("lb05s", 1'b0, 7'h05, 2'b00, 1'b1, 32'h0, 4, 1'b0, rd);
    check("lb05s.rdata", rd, 32'hFFFFFFAA);
    access("lb05z", 1'b0, 7'h05, 2'b00, 1'b0, 32'h0, 4, 1'b0, rd);
    check("lb05z.rdata", rd, 32'h000000AA);
    access("lb07z", 1'b0, 7'h07, 2'b00, 1'b0, 32'h0, 4, 1'b0, rd);
    check("lb07z.rdata", rd, 32'h000000DE);
    access("lb07s", 1'b0, 7'h07, 2'b00, 1'b1, 32'h0, 4, 1'b0, rd);
    check("lb07s.rdata", rd, 32'hFFFFFFDE);

    access("lh06s", 1'b0, 7'h06, 2'b01, 1'b1, 32'h0, 4, 1'b0, rd);
    check("lh06s.rdata", rd, 32'hFFFFDEAD);
    access("lh06z", 1'b0, 7'h06, 2'b01, 1'b0, 32'h0, 4, 1'b0, rd);
    check("lh06z.rdata", rd, 32'h0000DEAD);
    access("lh04s", 1'b0, 7'h04, 2'b01, 1'b1, 32'h0, 4, 1'b0, rd);
    check("lh04s.rdata", rd, 32'hFFFFAAEF);

    access("sw00", 1'b1, 7'h00, 2'b10, 1'b0, 32'h00C0FFEE, 4, 1'b0, rd);
    check("sw00.rdata_held", rd, 32'hFFFFAAEF);
    access("lw02", 1'b0, 7'h02, 2'b10, 1'b0, 32'h0, 1, 1'b1, rd);
    check("lw02.rdata_held", rd, 32'hFFFFAAEF);
    access("s11", 1'b1, 7'h00, 2'b11, 1'b0, 32'hFFFFFFFF, 1, 1'b1, rd);
    check("s11.rdata_held", rd, 32'hFFFFAAEF);
    access("sh05", 1'b1, 7'h05, 2'b01, 1'b0, 32'h00001111, 1, 1'b1, rd);
    check("sh05.rdata_held", rd, 32'hFFFFAAEF);
    access("lw00", 1'b0, 7'h00, 2'b10, 1'b0, 32'h0, 4, 1'b0, rd);
    check("lw00.rdata", rd, 32'h00C0FFEE);
    access("lw04c", 1'b0, 7'h04, 2'b10, 1'b0, 32'h0, 4, 1'b0, rd);
    check("lw04c.rdata", rd, 32'hDEADAAEF);

    // req held high across two stores; the second is taken only once IDLE returns.
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 7'h08; size = 2'b10; sign_ext = 1'b0; wdata = 32'hA5A5A5A5;
    @(posedge clk);
    #1;
    addr = 7'h0C; wdata = 32'h5A5A5A5A;
    rv = '0; bv = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      rv[k] = ready;
      bv[k] = busy;
      if (k == 9) req = 1'b0;
    end
    check("b2b.ready_pattern", {21'h0, rv}, 32'h210);
    check("b2b.busy_pattern",  {21'h0, bv}, 32'h3DE);
    access("lw08", 1'b0, 7'h08, 2'b10, 1'b0, 32'h0, 4, 1'b0, rd);
    check("lw08.rdata", rd, 32'hA5A5A5A5);
    access("lw0c", 1'b0, 7'h0C, 2'b10, 1'b0, 32'h0, 4, 1'b0, rd);
    check("lw0c.rdata", rd, 32'h5A5A5A5A);

    // Reset while the store is still waiting must abort it.
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 7'h04; size = 2'b10; wdata = 32'h12345678;
    @(posedge clk);
    #1;
    req = 1'b0;
    @(negedge clk);
    check("abort.busy_before", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort.ready", {31'h0, ready}, 32'h0);
    check("abort.busy",  {31'h0, busy},  32'h0);
    check("abort.rdata", rdata, 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort.idle_ready", {31'h0, ready}, 32'h0);
    access("lw04d", 1'b0, 7'h04, 2'b10, 1'b0, 32'h0, 4, 1'b0, rd);
    check("lw04d.rdata", rd, 32'hDEADAAEF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
